// File: rtl/utrap_pkg.sv
// Shared definitions for the user-mode trap/CSR unit: CSR addresses, cause codes,
// CSR op encodings and status/interrupt bit positions.
package utrap_pkg;

    localparam logic [11:0] CSR_USTATUS  = 12'h000;
    localparam logic [11:0] CSR_UIE      = 12'h004;
    localparam logic [11:0] CSR_UTVEC    = 12'h005;
    localparam logic [11:0] CSR_USCRATCH = 12'h040;
    localparam logic [11:0] CSR_UEPC     = 12'h041;
    localparam logic [11:0] CSR_UCAUSE   = 12'h042;
    localparam logic [11:0] CSR_UTVAL    = 12'h043;
    localparam logic [11:0] CSR_UIP      = 12'h044;

    localparam int US_UIE  = 0;
    localparam int US_UPIE = 4;

    localparam int IRQ_USI = 0;
    localparam int IRQ_UTI = 4;
    localparam int IRQ_UEI = 8;

    localparam logic [31:0] UIE_MASK = 32'h0000_0111;

    localparam logic [30:0] CAUSE_IFETCH_MIS = 31'd0;
    localparam logic [30:0] CAUSE_ILLEGAL    = 31'd2;
    localparam logic [30:0] CAUSE_EBREAK     = 31'd3;
    localparam logic [30:0] CAUSE_LD_MIS     = 31'd4;
    localparam logic [30:0] CAUSE_ST_MIS     = 31'd6;
    localparam logic [30:0] CAUSE_ECALL      = 31'd8;
    localparam logic [30:0] CAUSE_USI        = 31'd0;
    localparam logic [30:0] CAUSE_UTI        = 31'd4;
    localparam logic [30:0] CAUSE_UEI        = 31'd8;

    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        TVAL_ZERO,
        TVAL_PC,
        TVAL_INST,
        TVAL_ADDR
    } tval_sel_e;

endpackage

// File: rtl/utrap_cause_arb.sv
// Priority encoder: interrupts preempt, then exceptions in architectural order.
// Produces the trap strobe, the full ucause value and which source feeds utval.
module utrap_cause_arb
    import utrap_pkg::*;
(
    input  logic        i_ifetch_mis,
    input  logic        i_illegal,
    input  logic        i_csr_bad,
    input  logic        i_ebreak,
    input  logic        i_ecall,
    input  logic        i_ld_mis,
    input  logic        i_st_mis,
    input  logic        i_int_usi,
    input  logic        i_int_uti,
    input  logic        i_int_uei,
    output logic        o_trap,
    output logic [31:0] o_cause,
    output tval_sel_e   o_tval_sel
);

    always_comb begin
        o_trap     = 1'b1;
        o_cause    = 32'h0;
        o_tval_sel = TVAL_ZERO;
        if (i_int_uei)         o_cause = {1'b1, CAUSE_UEI};
        else if (i_int_usi)    o_cause = {1'b1, CAUSE_USI};
        else if (i_int_uti)    o_cause = {1'b1, CAUSE_UTI};
        else if (i_ifetch_mis) begin
            o_cause    = {1'b0, CAUSE_IFETCH_MIS};
            o_tval_sel = TVAL_ADDR;
        end else if (i_illegal) begin
            o_cause    = {1'b0, CAUSE_ILLEGAL};
            o_tval_sel = TVAL_INST;
        end else if (i_csr_bad) o_cause = {1'b0, CAUSE_ILLEGAL};
        else if (i_ebreak) begin
            o_cause    = {1'b0, CAUSE_EBREAK};
            o_tval_sel = TVAL_PC;
        end else if (i_ecall)  o_cause = {1'b0, CAUSE_ECALL};
        else if (i_ld_mis) begin
            o_cause    = {1'b0, CAUSE_LD_MIS};
            o_tval_sel = TVAL_ADDR;
        end else if (i_st_mis) begin
            o_cause    = {1'b0, CAUSE_ST_MIS};
            o_tval_sel = TVAL_ADDR;
        end else       o_trap = 1'b0;
    end

endmodule

// File: rtl/utrap_csr.sv
// User-mode trap and CSR unit for the single-cycle RV32 core.
// Optional UTRAP_VECTORED_EN makes utvec[0] a MODE bit that vectors interrupts.
module utrap_csr
    import utrap_pkg::*;
#(
    parameter logic [31:0] UTVEC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        exc_ifetch_mis,
    input  logic        exc_illegal,
    input  logic        exc_ebreak,
    input  logic        exc_ecall,
    input  logic        exc_ld_mis,
    input  logic        exc_st_mis,
    input  logic [31:0] bad_addr,
    input  logic [31:0] bad_inst,
    input  logic        irq_ext,
    input  logic        irq_timer,
    input  logic        uret_req,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        trap,
    output logic [31:0] utvec,
    output logic        uret,
    output logic [31:0] epc,
    output logic        inst_kill
);

`ifdef UTRAP_VECTORED_EN
    localparam logic [31:0] UTVEC_MASK = 32'hFFFF_FFFD;
`else
    localparam logic [31:0] UTVEC_MASK = 32'hFFFF_FFFC;
`endif

    logic        r_uie, r_upie, r_usip;
    logic [31:0] r_uie_en, r_utvec, r_uscratch, r_uepc, r_ucause, r_utval;

    logic [31:0] w_ustatus, w_uip, w_csr_old, w_csr_new, w_cause, w_tval, w_base;
    logic        w_csr_hit, w_csr_bad, w_csr_we, w_arb_trap, w_trap;
    logic        w_int_usi, w_int_uti, w_int_uei;
    csr_op_e     w_op;
    tval_sel_e   w_tval_sel;

    always_comb begin
        w_ustatus          = 32'h0;
        w_ustatus[US_UIE]  = r_uie;
        w_ustatus[US_UPIE] = r_upie;
        w_uip              = 32'h0;
        w_uip[IRQ_USI]     = r_usip;
        w_uip[IRQ_UTI]     = irq_timer;
        w_uip[IRQ_UEI]     = irq_ext;
    end

    assign w_int_usi = r_uie & r_uie_en[IRQ_USI] & r_usip;
    assign w_int_uti = r_uie & r_uie_en[IRQ_UTI] & irq_timer;
    assign w_int_uei = r_uie & r_uie_en[IRQ_UEI] & irq_ext;

    assign w_op = csr_op_e'(csr_op);

    always_comb begin
        w_csr_hit = 1'b1;
        w_csr_old = 32'h0;
        case (csr_addr)
            CSR_USTATUS:  w_csr_old = w_ustatus;
            CSR_UIE:      w_csr_old = r_uie_en;
            CSR_UTVEC:    w_csr_old = r_utvec;
            CSR_USCRATCH: w_csr_old = r_uscratch;
            CSR_UEPC:     w_csr_old = r_uepc;
            CSR_UCAUSE:   w_csr_old = r_ucause;
            CSR_UTVAL:    w_csr_old = r_utval;
            CSR_UIP:      w_csr_old = w_uip;
            default:      w_csr_hit = 1'b0;
        endcase
    end

    always_comb begin
        case (w_op)
            CSR_RW:  w_csr_new = csr_wdata;
            CSR_RS:  w_csr_new = w_csr_old | csr_wdata;
            CSR_RC:  w_csr_new = w_csr_old & ~csr_wdata;
            default: w_csr_new = w_csr_old;
        endcase
    end

    assign w_csr_bad = (w_op != CSR_NONE) & ~w_csr_hit;

    utrap_cause_arb u_arb (
        .i_ifetch_mis (exc_ifetch_mis),
        .i_illegal    (exc_illegal),
        .i_csr_bad    (w_csr_bad),
        .i_ebreak     (exc_ebreak),
        .i_ecall      (exc_ecall),
        .i_ld_mis     (exc_ld_mis),
        .i_st_mis     (exc_st_mis),
        .i_int_usi    (w_int_usi),
        .i_int_uti    (w_int_uti),
        .i_int_uei    (w_int_uei),
        .o_trap       (w_arb_trap),
        .o_cause      (w_cause),
        .o_tval_sel   (w_tval_sel)
    );

    assign w_trap = w_arb_trap & ~rst;
    // Set/clear with a zero operand is a pure read and must not write.
    assign w_csr_we = ~rst & ~w_trap & w_csr_hit & (w_op != CSR_NONE)
                    & ~(((w_op == CSR_RS) | (w_op == CSR_RC)) & (csr_wdata == 32'h0));

    always_comb begin
        case (w_tval_sel)
            TVAL_PC:   w_tval = pc;
            TVAL_INST: w_tval = bad_inst;
            TVAL_ADDR: w_tval = bad_addr;
            default:   w_tval = 32'h0;
        endcase
    end

    assign w_base = {r_utvec[31:2], 2'b00};
`ifdef UTRAP_VECTORED_EN
    assign utvec = (r_utvec[0] & w_cause[31]) ? w_base + {w_cause[29:0], 2'b00} : w_base;
`else
    assign utvec = w_base;
`endif

    assign trap      = w_trap;
    assign inst_kill = w_trap;
    assign uret      = uret_req & ~w_trap & ~rst;
    assign epc       = r_uepc;
    assign csr_rdata = rst ? 32'h0 : w_csr_old;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_uie      <= 1'b0;
            r_upie     <= 1'b0;
            r_usip     <= 1'b0;
            r_uie_en   <= 32'h0;
            r_utvec    <= UTVEC_RESET & UTVEC_MASK;
            r_uscratch <= 32'h0;
            r_uepc     <= 32'h0;
            r_ucause   <= 32'h0;
            r_utval    <= 32'h0;
        end else if (w_trap) begin
            r_upie   <= r_uie;
            r_uie    <= 1'b0;
            r_uepc   <= {pc[31:2], 2'b00};
            r_ucause <= w_cause;
            r_utval  <= w_tval;
        end else begin
            if (w_csr_we) begin
                case (csr_addr)
                    CSR_USTATUS: begin
                        r_uie  <= w_csr_new[US_UIE];
                        r_upie <= w_csr_new[US_UPIE];
                    end
                    CSR_UIE:      r_uie_en   <= w_csr_new & UIE_MASK;
                    CSR_UTVEC:    r_utvec    <= w_csr_new & UTVEC_MASK;
                    CSR_USCRATCH: r_uscratch <= w_csr_new;
                    CSR_UEPC:     r_uepc     <= {w_csr_new[31:2], 2'b00};
                    CSR_UCAUSE:   r_ucause   <= w_csr_new;
                    CSR_UTVAL:    r_utval    <= w_csr_new;
                    CSR_UIP:      r_usip     <= w_csr_new[IRQ_USI];
                    default: ;
                endcase
            end
            // URET reads the pre-instruction UPIE and overrides any same-cycle ustatus write.
            if (uret) begin
                r_uie  <= r_upie;
                r_upie <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_utrap_csr.sv
// Bench for utrap_csr: directed vector table, reset corner cases, then random
// stimulus against a behavioural CSR/trap model.
module tb_utrap_csr;

    logic        clk, rst;
    logic [31:0] pc, bad_addr, bad_inst, csr_wdata, csr_rdata, utvec, epc;
    logic        exc_ifetch_mis, exc_illegal, exc_ebreak, exc_ecall, exc_ld_mis, exc_st_mis;
    logic        irq_ext, irq_timer, uret_req, trap, uret, inst_kill;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;

    int n_pass = 0;
    int n_tot  = 0;

    localparam logic [31:0] RSTV = 32'h0040_0100;
`ifdef UTRAP_VECTORED_EN
    localparam logic [31:0] UTV_MASK = 32'hFFFF_FFFD;
`else
    localparam logic [31:0] UTV_MASK = 32'hFFFF_FFFC;
`endif

    utrap_csr #(.UTVEC_RESET(RSTV)) dut (
        .clk(clk), .rst(rst), .pc(pc),
        .exc_ifetch_mis(exc_ifetch_mis), .exc_illegal(exc_illegal),
        .exc_ebreak(exc_ebreak), .exc_ecall(exc_ecall),
        .exc_ld_mis(exc_ld_mis), .exc_st_mis(exc_st_mis),
        .bad_addr(bad_addr), .bad_inst(bad_inst),
        .irq_ext(irq_ext), .irq_timer(irq_timer), .uret_req(uret_req),
        .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .trap(trap), .utvec(utvec),
        .uret(uret), .epc(epc), .inst_kill(inst_kill)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] pc;
        logic [5:0]  exc;   // ifetch, illegal, ebreak, ecall, ld, st
        logic [31:0] baddr, binst;
        logic        iext, itim, ureq;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wd;
        logic        etrap, euret;
        logic [31:0] erd, eepc, eutv;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t f_mk(logic [31:0] p, logic [5:0] e, logic [31:0] ba, logic [31:0] bi,
                                  logic ie, logic it, logic ur, logic [1:0] op, logic [11:0] a,
                                  logic [31:0] wd, logic et, logic eu, logic [31:0] erd, logic [31:0] eepc);
        vec_t v;
        v.pc = p; v.exc = e; v.baddr = ba; v.binst = bi; v.iext = ie; v.itim = it; v.ureq = ur;
        v.op = op; v.addr = a; v.wd = wd; v.etrap = et; v.euret = eu; v.erd = erd; v.eepc = eepc;
        v.eutv = RSTV;
        return v;
    endfunction

    function automatic vec_t f_rd(logic [11:0] a, logic [31:0] e, logic [31:0] ep);
        return f_mk(32'h0040_0000, 6'b0, 0, 0, 0, 0, 0, 2'b10, a, 0, 0, 0, e, ep);
    endfunction

    function automatic vec_t f_wr(logic [1:0] op, logic [11:0] a, logic [31:0] wd, logic [31:0] e, logic [31:0] ep);
        return f_mk(32'h0040_0000, 6'b0, 0, 0, 0, 0, 0, op, a, wd, 0, 0, e, ep);
    endfunction

    function automatic vec_t f_ex(logic [31:0] p, logic [5:0] e, logic [31:0] ba, logic [31:0] bi,
                                  logic [31:0] erd, logic [31:0] ep);
        return f_mk(p, e, ba, bi, 0, 0, 0, 2'b00, 12'h000, 0, 1, 0, erd, ep);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %h want %h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input vec_t v);
        pc = v.pc;
        {exc_ifetch_mis, exc_illegal, exc_ebreak, exc_ecall, exc_ld_mis, exc_st_mis} = v.exc;
        bad_addr = v.baddr; bad_inst = v.binst;
        irq_ext = v.iext; irq_timer = v.itim; uret_req = v.ureq;
        csr_op = v.op; csr_addr = v.addr; csr_wdata = v.wd;
    endtask

    task automatic apply(input vec_t v, input string tag);
        drive(v);
        @(negedge clk);
        check({tag, ".trap"}, {31'b0, trap}, {31'b0, v.etrap});
        check({tag, ".kill"}, {31'b0, inst_kill}, {31'b0, v.etrap});
        check({tag, ".uret"}, {31'b0, uret}, {31'b0, v.euret});
        check({tag, ".rdata"}, csr_rdata, v.erd);
        check({tag, ".epc"}, epc, v.eepc);
        check({tag, ".utvec"}, utvec, v.eutv);
        @(posedge clk); #1;
    endtask

    // Behavioural model state
    logic [31:0] m_ust, m_uie, m_utv, m_scr, m_epc, m_cause, m_tval;
    logic        m_usip;

    function automatic logic [31:0] m_read(logic [11:0] a, logic ie, logic it);
        case (a)
            12'h000: return m_ust;
            12'h004: return m_uie;
            12'h005: return m_utv;
            12'h040: return m_scr;
            12'h041: return m_epc;
            12'h042: return m_cause;
            12'h043: return m_tval;
            12'h044: return (32'(ie) << 8) | (32'(it) << 4) | 32'(m_usip);
            default: return 32'h0;
        endcase
    endfunction

    task automatic rnd_cycle(input int n);
        logic [11:0] addrs[9] = '{12'h000, 12'h004, 12'h005, 12'h040, 12'h041, 12'h042, 12'h043, 12'h044, 12'h7C0};
        int          codes[6] = '{0, 2, 3, 8, 4, 6};
        logic [31:0] tvals[6];
        logic        vld[6];
        logic [31:0] act, old, nv, e_cause, e_tval, e_tgt, ust0;
        logic        hit, bad, is_int, e_trap, e_uret, found;
        logic [5:0]  ex;
        int          code;

        pc = $urandom & 32'hFFFF_FFFC;
        for (int b = 0; b < 6; b++) ex[b] = ($urandom_range(0, 9) == 0);
        {exc_ifetch_mis, exc_illegal, exc_ebreak, exc_ecall, exc_ld_mis, exc_st_mis} = ex;
        bad_addr = $urandom; bad_inst = $urandom;
        irq_ext = ($urandom_range(0, 3) == 0); irq_timer = ($urandom_range(0, 3) == 0);
        uret_req = ($urandom_range(0, 5) == 0);
        csr_op = 2'($urandom_range(0, 3));
        csr_addr = ($urandom_range(0, 15) == 0) ? 12'($urandom) : addrs[$urandom_range(0, 8)];
        csr_wdata = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;

        hit = csr_addr inside {12'h000, 12'h004, 12'h005, 12'h040, 12'h041, 12'h042, 12'h043, 12'h044};
        bad = (csr_op != 2'b00) && !hit;
        old = m_read(csr_addr, irq_ext, irq_timer);
        act = m_uie & ((32'(irq_ext) << 8) | (32'(irq_timer) << 4) | 32'(m_usip));
        is_int = m_ust[0] && (act != 0);
        vld = '{exc_ifetch_mis, exc_illegal | bad, exc_ebreak, exc_ecall, exc_ld_mis, exc_st_mis};
        tvals = '{bad_addr, exc_illegal ? bad_inst : 32'h0, pc, 32'h0, bad_addr, bad_addr};
        e_cause = 0; e_tval = 0; found = 0; code = 0;
        if (is_int) begin
            code = act[8] ? 8 : (act[0] ? 0 : 4);
            e_cause = 32'h8000_0000 | 32'(code);
        end else begin
            for (int k = 0; k < 6; k++)
                if (vld[k] && !found) begin
                    found = 1; e_cause = 32'(codes[k]); e_tval = tvals[k];
                end
        end
        e_trap = is_int || found;
        e_uret = uret_req && !e_trap;
        e_tgt = m_utv & 32'hFFFF_FFFC;
`ifdef UTRAP_VECTORED_EN
        if (is_int && m_utv[0]) e_tgt = e_tgt + 32'(4 * code);
`endif

        @(negedge clk);
        check($sformatf("rnd%0d.trap", n), {31'b0, trap}, {31'b0, e_trap});
        check($sformatf("rnd%0d.kill", n), {31'b0, inst_kill}, {31'b0, e_trap});
        check($sformatf("rnd%0d.uret", n), {31'b0, uret}, {31'b0, e_uret});
        check($sformatf("rnd%0d.rdata", n), csr_rdata, old);
        check($sformatf("rnd%0d.epc", n), epc, m_epc);
        check($sformatf("rnd%0d.utvec", n), utvec, e_tgt);
        @(posedge clk); #1;

        if (e_trap) begin
            m_ust = m_ust[0] ? 32'h10 : 32'h0;
            m_epc = pc & 32'hFFFF_FFFC; m_cause = e_cause; m_tval = e_tval;
        end else begin
            ust0 = m_ust;
            if (hit && csr_op != 2'b00 && !(csr_op[1] && csr_wdata == 0)) begin
                nv = (csr_op == 2'b01) ? csr_wdata : (csr_op == 2'b10) ? (old | csr_wdata) : (old & ~csr_wdata);
                case (csr_addr)
                    12'h000: m_ust = nv & 32'h11;
                    12'h004: m_uie = nv & 32'h111;
                    12'h005: m_utv = nv & UTV_MASK;
                    12'h040: m_scr = nv;
                    12'h041: m_epc = nv & 32'hFFFF_FFFC;
                    12'h042: m_cause = nv;
                    12'h043: m_tval = nv;
                    default: m_usip = nv[0];
                endcase
            end
            if (e_uret) m_ust = 32'h10 | ((ust0 >> 4) & 32'h1);
        end
    endtask

    localparam logic [31:0] A = 32'h0040_0010, B = 32'h0040_0020, C = 32'h0040_0030;
    localparam logic [31:0] D = 32'h0040_0014, E = 32'h0040_0040, F = 32'h0040_0050;
    localparam logic [31:0] G = 32'h0040_0060, H = 32'h0040_0070, I = 32'h0040_0080;
    localparam logic [31:0] J = 32'h0040_0090, K = 32'h0040_00A0, L = 32'hFFFF_FFFC;

    initial begin
        vec_t v;
        rst = 1'b1;
        drive(f_mk(0, 0, 0, 0, 1, 1, 1, 2'b01, 12'h005, 32'hFFFF_FFFF, 0, 0, 0, 0));
        exc_ecall = 1'b1;
        @(negedge clk);
        check("rst.trap", {31'b0, trap}, 32'h0);
        check("rst.uret", {31'b0, uret}, 32'h0);
        check("rst.kill", {31'b0, inst_kill}, 32'h0);
        check("rst.rdata", csr_rdata, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Reset values
        tbl.push_back(f_rd(12'h000, 0, 0));
        tbl.push_back(f_rd(12'h004, 0, 0));
        tbl.push_back(f_rd(12'h005, RSTV, 0));
        tbl.push_back(f_rd(12'h040, 0, 0));
        tbl.push_back(f_rd(12'h041, 0, 0));
        tbl.push_back(f_rd(12'h042, 0, 0));
        tbl.push_back(f_rd(12'h043, 0, 0));
        tbl.push_back(f_rd(12'h044, 0, 0));
        // ECALL with UIE set beforehand
        tbl.push_back(f_wr(2'b01, 12'h000, 32'h1, 0, 0));
        tbl.push_back(f_ex(A, 6'b000100, 0, 0, 32'h1, 0));
        tbl.push_back(f_rd(12'h042, 8, A));
        tbl.push_back(f_rd(12'h000, 32'h10, A));
        tbl.push_back(f_rd(12'h041, A, A));
        tbl.push_back(f_rd(12'h043, 0, A));
        // External + timer interrupt, external wins
        tbl.push_back(f_wr(2'b01, 12'h004, 32'h110, 0, A));
        tbl.push_back(f_wr(2'b10, 12'h000, 32'h1, 32'h10, A));
        tbl.push_back(f_mk(B, 0, 0, 0, 1, 1, 0, 2'b00, 12'h044, 0, 1, 0, 32'h110, A));
        tbl.push_back(f_rd(12'h042, 32'h8000_0008, B));
        tbl.push_back(f_rd(12'h000, 32'h10, B));
        // CSRRS ustatus in the same cycle as a load misalign: write suppressed
        tbl.push_back(f_mk(C, 6'b000010, 32'h1003, 0, 0, 0, 0, 2'b10, 12'h000, 32'h1, 1, 0, 32'h10, B));
        tbl.push_back(f_rd(12'h000, 0, C));
        tbl.push_back(f_rd(12'h042, 4, C));
        tbl.push_back(f_rd(12'h043, 32'h1003, C));
        // URET, then URET colliding with an enabled interrupt
        tbl.push_back(f_wr(2'b01, 12'h041, D, C, C));
        tbl.push_back(f_wr(2'b01, 12'h000, 32'h10, 0, D));
        tbl.push_back(f_mk(32'h0040_0038, 0, 0, 0, 0, 0, 1, 2'b00, 12'h041, 0, 0, 1, D, D));
        tbl.push_back(f_rd(12'h000, 32'h11, D));
        tbl.push_back(f_mk(E, 0, 0, 0, 1, 0, 1, 2'b00, 12'h000, 0, 1, 0, 32'h11, D));
        tbl.push_back(f_rd(12'h042, 32'h8000_0008, E));
        // Unimplemented CSR
        tbl.push_back(f_mk(F, 0, 0, 32'hDEAD_BEEF, 0, 0, 0, 2'b01, 12'h7C0, 32'hFFFF_FFFF, 1, 0, 0, E));
        tbl.push_back(f_rd(12'h042, 2, F));
        tbl.push_back(f_rd(12'h043, 0, F));
        tbl.push_back(f_rd(12'h040, 0, F));
        tbl.push_back(f_rd(12'h000, 0, F));
        // Exception priority
        tbl.push_back(f_ex(G, 6'b110100, 0, 32'h1234_5678, 0, F));
        tbl.push_back(f_rd(12'h042, 0, G));
        tbl.push_back(f_ex(H, 6'b011000, 0, 32'h1234_5678, 0, G));
        tbl.push_back(f_rd(12'h042, 2, H));
        tbl.push_back(f_rd(12'h043, 32'h1234_5678, H));
        tbl.push_back(f_ex(I, 6'b001100, 0, 0, 0, H));
        tbl.push_back(f_rd(12'h042, 3, I));
        tbl.push_back(f_rd(12'h043, I, I));
        tbl.push_back(f_ex(J, 6'b000011, 32'h2002, 0, 0, I));
        tbl.push_back(f_rd(12'h042, 4, J));
        tbl.push_back(f_rd(12'h043, 32'h2002, J));
        tbl.push_back(f_ex(K, 6'b000001, 32'h3001, 0, 0, J));
        tbl.push_back(f_rd(12'h042, 6, K));
        tbl.push_back(f_rd(12'h043, 32'h3001, K));
        // Masked and read-only bits, set/clear ops
        tbl.push_back(f_wr(2'b01, 12'h041, 32'hFFFF_FFFF, K, K));
        tbl.push_back(f_rd(12'h041, L, L));
        tbl.push_back(f_wr(2'b01, 12'h044, 32'hFFFF_FFFF, 0, L));
        tbl.push_back(f_rd(12'h044, 1, L));
        tbl.push_back(f_wr(2'b11, 12'h044, 32'h1, 1, L));
        tbl.push_back(f_rd(12'h044, 0, L));
        tbl.push_back(f_wr(2'b01, 12'h040, 32'hA5A5_A5A5, 0, L));
        tbl.push_back(f_wr(2'b11, 12'h040, 32'h0000_FFFF, 32'hA5A5_A5A5, L));
        tbl.push_back(f_rd(12'h040, 32'hA5A5_0000, L));
        tbl.push_back(f_wr(2'b01, 12'h005, 32'h1234_5676, RSTV, L));
        v = f_rd(12'h005, 32'h1234_5674, L); v.eutv = 32'h1234_5674; tbl.push_back(v);
        v = f_wr(2'b01, 12'h005, RSTV, 32'h1234_5674, L); v.eutv = 32'h1234_5674; tbl.push_back(v);
        tbl.push_back(f_rd(12'h005, RSTV, L));
`ifdef UTRAP_VECTORED_EN
        tbl.push_back(f_wr(2'b01, 12'h005, RSTV | 32'h1, RSTV, L));
        tbl.push_back(f_wr(2'b01, 12'h004, 32'h110, 32'h110, L));
        tbl.push_back(f_wr(2'b01, 12'h000, 32'h1, 0, L));
        v = f_mk(32'h0040_0300, 0, 0, 0, 1, 0, 0, 2'b00, 12'h000, 0, 1, 0, 32'h1, L);
        v.eutv = RSTV + 32'h20; tbl.push_back(v);
        tbl.push_back(f_wr(2'b01, 12'h000, 32'h1, 32'h10, 32'h0040_0300));
        v = f_mk(32'h0040_0304, 0, 0, 0, 0, 1, 0, 2'b00, 12'h000, 0, 1, 0, 32'h1, 32'h0040_0300);
        v.eutv = RSTV + 32'h10; tbl.push_back(v);
        tbl.push_back(f_ex(32'h0040_0308, 6'b000100, 0, 0, 32'h10, 32'h0040_0304));
        tbl.push_back(f_wr(2'b01, 12'h005, RSTV, RSTV | 32'h1, 32'h0040_0308));
`endif
        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Reset mid-run blocks a trap/uret/write; a trap in the first cycle out of reset is taken
        rst = 1'b1;
        drive(f_mk(32'h0040_0200, 6'b000100, 0, 0, 1, 0, 1, 2'b01, 12'h040, 32'hFFFF, 0, 0, 0, 0));
        @(negedge clk);
        check("rst2.trap", {31'b0, trap}, 32'h0);
        check("rst2.uret", {31'b0, uret}, 32'h0);
        check("rst2.kill", {31'b0, inst_kill}, 32'h0);
        check("rst2.rdata", csr_rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        apply(f_mk(32'h0040_0200, 6'b000100, 0, 0, 0, 0, 1, 2'b00, 12'h040, 0, 1, 0, 0, 0), "rst3");
        apply(f_rd(12'h042, 8, 32'h0040_0200), "rst4");
        apply(f_rd(12'h005, RSTV, 32'h0040_0200), "rst5");

        m_ust = 0; m_uie = 0; m_utv = RSTV & UTV_MASK; m_scr = 0;
        m_epc = 32'h0040_0200; m_cause = 8; m_tval = 0; m_usip = 0;
        for (int n = 0; n < 3000; n++) rnd_cycle(n);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/utrap_csr.md
# utrap_csr

User-mode trap and CSR unit for the single-cycle RV32 core. It holds the N-extension CSRs (ustatus, uie, utvec, uscratch, uepc, ucause, utval, uip) and arbitrates synchronous exceptions against level-sensitive interrupts. It drives the PC register's redirect inputs: `trap` with target `utvec`, and `uret` with return address `epc`. It also serves CSR-instruction reads and writes for the datapath.

## Interface
- UTVEC_RESET, 32'h0000_0000: reset value of utvec (BASE and MODE).
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- pc  in  32  address of the instruction executing this cycle.
- exc_ifetch_mis  in  1  instruction-address-misaligned for this instruction.
- exc_illegal  in  1  illegal instruction from the decoder.
- exc_ebreak, exc_ecall  in  1 each  EBREAK / ECALL decoded.
- exc_ld_mis, exc_st_mis  in  1 each  load/store address misaligned.
- bad_addr  in  32  faulting address for misaligned exceptions.
- bad_inst  in  32  instruction word, recorded for illegal instructions.
- irq_ext, irq_timer  in  1 each  level interrupt sources, already in the clk domain.
- uret_req  in  1  URET decoded.
- csr_op  in  2  00 none, 01 RW, 10 RS, 11 RC.
- csr_addr  in  12  CSR address.
- csr_wdata  in  32  rs1 or zimm operand.
- csr_rdata  out  32  old CSR value, combinational.
- trap  out  1  redirect to `utvec` at the next edge.
- utvec  out  32  trap target address.
- uret  out  1  redirect to `epc` at the next edge.
- epc  out  32  current uepc.
- inst_kill  out  1  suppresses register-file and memory writes of the current instruction.

## Operation
- **CSR addresses**
  - ustatus 0x000: bit0 UIE, bit4 UPIE; other bits read 0.
  - uie 0x004: bits 0, 4, 8.
  - utvec 0x005.
  - uscratch 0x040.
  - uepc 0x041: bits [1:0] read 0.
  - ucause 0x042.
  - utval 0x043.
  - uip 0x044: bit0 USIP is RW; bit4 UTIP = irq_timer and bit8 UEIP = irq_ext are read-only.
- **CSR ops**
  - RW writes wdata.
  - RS ORs wdata in; RC clears wdata bits. RS/RC with wdata = 0 causes no write.
  - Read-only bits ignore writes.
- **Unimplemented CSR**: csr_op != 00 to an unimplemented csr_addr is treated as an illegal instruction with utval = 0.
- **Interrupt pending**: int_pend = UIE & |(uie & uip).
  - Priority among interrupts: UEI (cause 8) > USI (0) > UTI (4).
  - An interrupt preempts the current instruction: uepc = pc, utval = 0, ucause[31] = 1.
- **Exceptions**
  - Priority: ifetch_mis (0) > illegal (2, utval = bad_inst) > ebreak (3, utval = pc) > ecall (8, utval = 0) > ld_mis (4) > st_mis (6).
  - ld_mis and st_mis record utval = bad_addr.
  - ucause[31] = 0; uepc = pc.
- **Trap sequencing**
  - trap = int_pend | any exception.
  - A trap asserts inst_kill and suppresses any CSR write in that cycle.
  - On the trap edge: UPIE <= UIE, UIE <= 0, and uepc, ucause, utval are captured.
- **URET**
  - uret = uret_req & ~trap.
  - On the edge: UIE <= UPIE, UPIE <= 1.
- **Trap target**: utvec output = {BASE[31:2], 2'b00}. In vectored mode, interrupts go to BASE + 4*cause[30:0].

## Timing
- Outputs are combinational from the current state and inputs. The PC register and this block commit on the same edge.
- Trap, CSR-write, and URET effects are visible to the next instruction; latency is 1 cycle.
- A write that sets UIE or uie is evaluated by the next instruction, never the current one.
- trap and uret are never both 1; trap wins.
- Reset values:
  - ustatus, uie, USIP, uscratch, uepc, ucause, utval = 0.
  - utvec = UTVEC_RESET.
- While rst = 1: trap, uret and inst_kill = 0, csr_rdata = 0, and state updates are blocked.
- A trap during the cycle rst deasserts is taken normally.
- A CSR write to uepc in the same cycle as uret: uret uses the old uepc; the new value is written.

## Configuration
- UTRAP_VECTORED_EN
  - Defined: utvec[0] is writable as MODE. MODE = 1 vectors interrupts; exceptions always go to BASE.
  - Undefined: utvec[1:0] are hardwired to 0 and every trap targets BASE.

## Structure
- Package utrap_pkg holds:
  - CSR address localparams;
  - cause codes;
  - csr_op encodings;
  - the ustatus bit indices.
- One sub-module, utrap_cause_arb, is natural: a combinational priority encoder that maps the exception and interrupt vectors to {trap, cause, tval_sel}.

## Test plan
- Reset with UTVEC_RESET = 0x0040_0100: all CSRs read back their reset values; trap = 0.
- ECALL at pc 0x0040_0010, utvec = 0x0040_0100:
  - trap = 1 and utvec = 0x0040_0100 in that cycle;
  - afterwards uepc = 0x0040_0010, ucause = 8, UIE = 0, UPIE = old UIE.
- UIE = 1, uie = 0x110, irq_ext and irq_timer both high: ucause = 0x8000_0008, inst_kill = 1. With the macro defined and MODE = 1, utvec = BASE + 0x20.
- CSRRS x5, ustatus with exc_ld_mis and bad_addr = 0x1003 in the same cycle: ustatus is unchanged, ucause = 4, utval = 0x1003.
- URET with uepc = 0x0040_0014 and UPIE = 1: uret = 1, epc = 0x0040_0014, and afterwards UIE = 1. The same cycle with irq_ext pending and enabled: trap = 1 and uret = 0.
- CSRRW to 0x7C0: illegal trap with ucause = 2 and utval = 0; no CSR is modified.
